// File: rtl/pair_stream_gen.sv
// Upstream feeder of the filter bank: one reference particle per filter, every home-cell
// neighbour broadcast to all filters, two phases per start, drained between reference indices.
module pair_stream_gen #(
  parameter int unsigned NUM_FILTER     = 7,
  parameter int unsigned FILTER_LATENCY = 4,
  parameter int unsigned ID_WIDTH       = 8,
  parameter int unsigned DATA_WIDTH     = 32
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  start,
  input  logic [NUM_FILTER-1:0][ID_WIDTH-1:0]   ref_count,
  input  logic [ID_WIDTH-1:0]                   nb_count,
  output logic [ID_WIDTH-1:0]                   ref_rd_addr,
  input  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_rd_data,
  output logic [ID_WIDTH-1:0]                   nb_rd_addr,
  input  logic [DATA_WIDTH-1:0]                 nb_rd_data,
  output logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_pos,
  output logic [DATA_WIDTH-1:0]                 nb_pos,
  output logic [ID_WIDTH-1:0]                   nb_id_out,
  output logic [NUM_FILTER-1:0]                 input_valid,
  output logic                                  phase,
  input  logic [NUM_FILTER-1:0]                 back_pressure,
  input  logic                                  all_buffer_empty,
  output logic                                  busy,
  output logic                                  done
);

  typedef logic [ID_WIDTH-1:0] id_t;
  localparam id_t IdOne = id_t'(1);

  // Last input_valid lands one cycle into DRAIN; FILTER_LATENCY+1 further cycles follow it.
  localparam int unsigned DrainCycles = FILTER_LATENCY + 2;
  localparam int unsigned CntWidth    = $clog2(DrainCycles + 1);
  typedef logic [CntWidth-1:0] cnt_t;
  localparam cnt_t DrainLast = cnt_t'(DrainCycles);

  typedef enum logic [2:0] {
    StIdle,
    StLoadRef,
    StWaitRef,
    StStream,
    StDrain,
    StNext,
    StFinish
  } state_e;

  state_e state_q, state_d;
  logic   phase_q, phase_d;
  id_t    ref_idx_q, ref_idx_d;
  id_t    nb_idx_q, nb_idx_d;
  id_t    nb_count_q, nb_count_d;
  id_t    max_ref_q, max_ref_d;
  cnt_t   drain_cnt_q, drain_cnt_d;
  logic   issue_q, issue_d;
  id_t    issue_id_q, issue_id_d;
  id_t    nb_id_q, nb_id_d;

  logic [NUM_FILTER-1:0][ID_WIDTH-1:0]   ref_count_q, ref_count_d;
  logic [NUM_FILTER-1:0][DATA_WIDTH-1:0] ref_pos_q, ref_pos_d;
  logic [DATA_WIDTH-1:0]                 nb_pos_q, nb_pos_d;
  logic [NUM_FILTER-1:0]                 valid_q, valid_d;

  id_t                   max_ref_in;
  logic [NUM_FILTER-1:0] active;
  logic                  stall;
  logic [ID_WIDTH:0]     ref_idx_inc;

  always_comb begin
    max_ref_in = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      if (ref_count[i] > max_ref_in) max_ref_in = ref_count[i];
    end
  end

  // Filters whose reference cell still holds a particle at the current ref_idx.
  always_comb begin
    active = '0;
    for (int i = 0; i < NUM_FILTER; i++) begin
      active[i] = ref_idx_q < ref_count_q[i];
    end
  end

  assign stall       = |(back_pressure & active);
  assign ref_idx_inc = {1'b0, ref_idx_q} + {{ID_WIDTH{1'b0}}, 1'b1};

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    ref_idx_d   = ref_idx_q;
    nb_idx_d    = nb_idx_q;
    nb_count_d  = nb_count_q;
    max_ref_d   = max_ref_q;
    ref_count_d = ref_count_q;
    drain_cnt_d = drain_cnt_q;
    issue_d     = 1'b0;
    issue_id_d  = issue_id_q;
    ref_pos_d   = ref_pos_q;

    // The read issued last cycle returns now and becomes a pair.
    valid_d  = issue_q ? active : '0;
    nb_pos_d = issue_q ? nb_rd_data : nb_pos_q;
    nb_id_d  = issue_q ? issue_id_q : nb_id_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d    = StLoadRef;
          phase_d    = 1'b0;
          ref_idx_d  = '0;
          nb_count_d = nb_count;
        end
      end
      StLoadRef: begin
        ref_count_d = ref_count;
        if (max_ref_in == '0 || nb_count_q == '0) begin
          // Zeroing max_ref makes NEXT close the whole phase.
          max_ref_d = '0;
          state_d   = StNext;
        end else begin
          max_ref_d = max_ref_in;
          state_d   = StWaitRef;
        end
      end
      StWaitRef: begin
        ref_pos_d = ref_rd_data;
        nb_idx_d  = '0;
        state_d   = StStream;
      end
      StStream: begin
        if (!stall) begin
          issue_d    = 1'b1;
          issue_id_d = nb_idx_q;
          if (nb_idx_q == nb_count_q - IdOne) begin
            drain_cnt_d = '0;
            state_d     = StDrain;
          end else begin
            nb_idx_d = nb_idx_q + IdOne;
          end
        end
      end
      StDrain: begin
        if (drain_cnt_q == DrainLast) begin
          if (all_buffer_empty) state_d = StNext;
        end else begin
          drain_cnt_d = drain_cnt_q + cnt_t'(1);
        end
      end
      StNext: begin
        if (ref_idx_inc < {1'b0, max_ref_q}) begin
          ref_idx_d = ref_idx_q + IdOne;
          state_d   = StLoadRef;
        end else if (!phase_q) begin
          phase_d   = 1'b1;
          ref_idx_d = '0;
          state_d   = StLoadRef;
        end else begin
          state_d = StFinish;
        end
      end
      StFinish: begin
        phase_d   = 1'b0;
        ref_idx_d = '0;
        nb_idx_d  = '0;
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      phase_q     <= 1'b0;
      ref_idx_q   <= '0;
      nb_idx_q    <= '0;
      nb_count_q  <= '0;
      max_ref_q   <= '0;
      ref_count_q <= '0;
      drain_cnt_q <= '0;
      issue_q     <= 1'b0;
      issue_id_q  <= '0;
      ref_pos_q   <= '0;
      nb_pos_q    <= '0;
      nb_id_q     <= '0;
      valid_q     <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      ref_idx_q   <= ref_idx_d;
      nb_idx_q    <= nb_idx_d;
      nb_count_q  <= nb_count_d;
      max_ref_q   <= max_ref_d;
      ref_count_q <= ref_count_d;
      drain_cnt_q <= drain_cnt_d;
      issue_q     <= issue_d;
      issue_id_q  <= issue_id_d;
      ref_pos_q   <= ref_pos_d;
      nb_pos_q    <= nb_pos_d;
      nb_id_q     <= nb_id_d;
      valid_q     <= valid_d;
    end
  end

  assign ref_rd_addr = ref_idx_q;
  assign nb_rd_addr  = nb_idx_q;
  assign ref_pos     = ref_pos_q;
  assign nb_pos      = nb_pos_q;
  assign nb_id_out   = nb_id_q;
  assign input_valid = valid_q;
  assign phase       = phase_q;
  assign busy        = (state_q != StIdle) && (state_q != StFinish);
  assign done        = (state_q == StFinish);

endmodule
